// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding for the frequency meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with rising-edge detect
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic rise
);

    logic meta;
    logic level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            meta    <= d_async;
            level   <= meta;
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period / high-time meter with activity timeout; FREQ_METER_DUTY_MEAS_EN adds high-time
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic             level;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .level   (level),
        .rise    (rise)
    );

`ifdef FREQ_METER_DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt;
`else
    logic unused_level;
    assign unused_level = level;
    assign high_time    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
`ifdef FREQ_METER_DUTY_MEAS_EN
            hcnt         <= '0;
            high_time    <= '0;
`endif
        end else begin
            period_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_MEASURE;
                        cnt   <= ONE_C;
`ifdef FREQ_METER_DUTY_MEAS_EN
                        hcnt  <= ONE_C;
`endif
                    end
                end
                ST_MEASURE: begin
                    // An edge landing on the timeout cycle still closes a valid period
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        cnt          <= ONE_C;
`ifdef FREQ_METER_DUTY_MEAS_EN
                        high_time    <= hcnt;
                        hcnt         <= ONE_C;
`endif
                    end else if (cnt == TIMEOUT_C) begin
                        state   <= ST_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt  <= cnt + ONE_C;
`ifdef FREQ_METER_DUTY_MEAS_EN
                        hcnt <= hcnt + CNT_W'(level);
`endif
                    end
                end
                ST_TIMEOUT: begin
                    // The interrupted period is dropped; this edge only rearms
                    if (rise) begin
                        state   <= ST_MEASURE;
                        timeout <= 1'b0;
                        cnt     <= ONE_C;
`ifdef FREQ_METER_DUTY_MEAS_EN
                        hcnt    <= ONE_C;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic [CNT_W-1:0] high_time;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pv_count = 0;
    int last_period = 0;
    int last_high = 0;
    bit pv_prev = 1'b0;
    bit pv_double = 1'b0;
    bit to_seen = 1'b0;

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .high_time    (high_time)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_valid) begin
            pv_count    = pv_count + 1;
            last_period = int'(period);
            last_high   = int'(high_time);
            if (pv_prev) pv_double = 1'b1;
        end
        if (timeout) to_seen = 1'b1;
        pv_prev = period_valid;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int h, input int p, input int n);
        repeat (n) begin
            sig_in = 1'b1;
            tick(h);
            sig_in = 1'b0;
            tick(p - h);
        end
    endtask

    function automatic int exp_high(input int h);
`ifdef FREQ_METER_DUTY_MEAS_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    initial begin
        #(100_000 * 20);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int base;

        tick(3);
        check("rst_period", int'(period), 0);
        check("rst_pv", int'(period_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_high", int'(high_time), 0);
        rst = 1'b0;
        tick(5);

        // 1: 200-cycle square wave, 50 high
        wave(50, 200, 4);
        check("t1_count", pv_count, 3);
        check("t1_period", last_period, 200);
        check("t1_high", last_high, exp_high(50));
        check("t1_timeout", int'(timeout), 0);

        // 2: one more edge, then silence
        k = cyc;
        sig_in = 1'b1;
        tick(50);
        sig_in = 1'b0;
        while (cyc < k + 1002) tick(1);
        check("t2_to_early", int'(timeout), 0);
        tick(1);
        check("t2_to_set", int'(timeout), 1);
        check("t2_period_hold", int'(period), 200);
        tick(100);
        check("t2_count", pv_count, 4);
        check("t2_to_level", int'(timeout), 1);

        // 3: resume with 300-cycle wave
        wave(100, 300, 1);
        check("t3_to_clear", int'(timeout), 0);
        check("t3_no_pulse", pv_count, 4);
        wave(100, 300, 1);
        check("t3_count", pv_count, 5);
        check("t3_period", last_period, 300);
        check("t3_high", last_high, exp_high(100));

        // 4: reset mid-period
        sig_in = 1'b1;
        tick(50);
        sig_in = 1'b0;
        tick(50);
        base = pv_count;
        rst = 1'b1;
        tick(2);
        check("t4_period", int'(period), 0);
        check("t4_timeout", int'(timeout), 0);
        check("t4_high", int'(high_time), 0);
        rst = 1'b0;
        tick(100);
        wave(50, 200, 1);
        check("t4_no_pulse", pv_count - base, 0);
        wave(50, 200, 2);
        check("t4_count", pv_count - base, 2);
        check("t4_period", last_period, 200);

        // 5: edges exactly TIMEOUT apart
        base = pv_count;
        to_seen = 1'b0;
        wave(50, 1000, 3);
        check("t5_count", pv_count - base, 3);
        check("t5_period", last_period, 1000);
        check("t5_high", last_high, exp_high(50));
        check("t5_no_timeout", int'(to_seen), 0);

        check("pv_single_cycle", int'(pv_double), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
